// File: rtl/fib_arb_pkg.sv
// fib_arb_pkg: shared FSM state type and sizing constants for fib_arb
package fib_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int DW_DEF = 20;
  localparam int IW_DEF = 5;
  localparam int MAX_I = 30;
endpackage

// File: rtl/fib_arb_rr.sv
// rr_arb2: two-way round-robin grant, favouring the requester that was not served last
module rr_arb2 (
  input  logic [1:0] pending,
  input  logic       last_grant,
  output logic       grant
);
  always_comb grant = &pending ? ~last_grant : pending[1];
endmodule

// File: rtl/fib_arb.sv
// fib_arb: two-requester arbiter for a shared Fibonacci engine; range check enabled by FIB_ARB_RANGE_CHK_EN
module fib_arb
  import fib_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_start,
  input  logic [IW-1:0] req0_i,
  output logic          req0_ready,
  output logic          req0_done_tick,
  output logic [DW-1:0] req0_f,
  output logic          req0_err,
  input  logic          req1_start,
  input  logic [IW-1:0] req1_i,
  output logic          req1_ready,
  output logic          req1_done_tick,
  output logic [DW-1:0] req1_f,
  output logic          req1_err,
  output logic          eng_start,
  output logic [IW-1:0] eng_i,
  input  logic          eng_ready,
  input  logic          eng_done_tick,
  input  logic [DW-1:0] eng_f
);
  state_t state_q, state_d;
  logic [1:0] pending_q, pending_d;
  logic last_grant_q, last_grant_d, grant_q, grant_d, arb_grant, oor, done;
  logic [IW-1:0] idx0_q, idx0_d, idx1_q, idx1_d, idx_g;
  logic [DW-1:0] f0_q, f0_d, f1_q, f1_d;
  rr_arb2 u_arb (.pending(pending_q), .last_grant(last_grant_q), .grant(arb_grant));
  assign idx_g = grant_q ? idx1_q : idx0_q;
`ifdef FIB_ARB_RANGE_CHK_EN
  assign oor = int'(idx_g) > MAX_I;
`else
  assign oor = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    last_grant_d = last_grant_q;
    grant_d = grant_q;
    idx0_d = idx0_q;
    idx1_d = idx1_q;
    f0_d = f0_q;
    f1_d = f1_q;
    if (req0_start && !pending_q[0]) begin
      pending_d[0] = 1'b1;
      idx0_d = req0_i;
    end
    if (req1_start && !pending_q[1]) begin
      pending_d[1] = 1'b1;
      idx1_d = req1_i;
    end
    case (state_q)
      IDLE: if (|pending_q) begin
        grant_d = arb_grant;
        state_d = ISSUE;
      end
      ISSUE: if (oor) begin
        f0_d = grant_q ? f0_q : '0;
        f1_d = grant_q ? '0 : f1_q;
        state_d = DONE;
      end else if (eng_ready) state_d = WAIT;
      WAIT: if (eng_done_tick) begin
        f0_d = grant_q ? f0_q : eng_f;
        f1_d = grant_q ? eng_f : f1_q;
        state_d = DONE;
      end
      DONE: begin
        pending_d[grant_q] = 1'b0;
        last_grant_d = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pending_q <= '0;
      last_grant_q <= 1'b1;
      grant_q <= 1'b0;
      idx0_q <= '0;
      idx1_q <= '0;
      f0_q <= '0;
      f1_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      last_grant_q <= last_grant_d;
      grant_q <= grant_d;
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
      f0_q <= f0_d;
      f1_q <= f1_d;
    end
  end
  assign done = reset_n && state_q == DONE;
  assign eng_start = reset_n && state_q == ISSUE && !oor && eng_ready;
  assign eng_i = idx_g;
  assign req0_ready = !pending_q[0] || !reset_n;
  assign req1_ready = !pending_q[1] || !reset_n;
  assign req0_done_tick = done && !grant_q;
  assign req1_done_tick = done && grant_q;
  assign req0_f = f0_q;
  assign req1_f = f1_q;
  assign req0_err = req0_done_tick && oor;
  assign req1_err = req1_done_tick && oor;
endmodule

// File: tb/tb_fib_arb.sv
// tb_fib_arb: scoreboard bench for fib_arb with a behavioural Fibonacci engine
module tb_fib_arb;
  localparam int DW = 20;
  localparam int IW = 5;
  typedef struct {bit req; logic [DW-1:0] f; bit err;} exp_t;
  logic clk = 0, reset_n = 0;
  logic req0_start = 0, req1_start = 0;
  logic [IW-1:0] req0_i = '0, req1_i = '0;
  logic req0_ready, req1_ready, req0_done_tick, req1_done_tick, req0_err, req1_err;
  logic [DW-1:0] req0_f, req1_f;
  logic eng_start, eng_ready, eng_done_tick;
  logic [IW-1:0] eng_i;
  logic [DW-1:0] eng_f;
  logic eng_busy, eng_hold = 0, inj_done = 0, model_done;
  logic [1:0] eng_cnt;
  logic [IW-1:0] eng_idx;
  logic [DW-1:0] model_f;
  int tests = 0, fails = 0;
  int exp_eng[$];
  exp_t exp_done[$];
  bit prev_start = 0, prev_eng_done = 0;
  always #5 clk = ~clk;
  fib_arb #(.DW(DW), .IW(IW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_start(req0_start), .req0_i(req0_i), .req0_ready(req0_ready),
    .req0_done_tick(req0_done_tick), .req0_f(req0_f), .req0_err(req0_err),
    .req1_start(req1_start), .req1_i(req1_i), .req1_ready(req1_ready),
    .req1_done_tick(req1_done_tick), .req1_f(req1_f), .req1_err(req1_err),
    .eng_start(eng_start), .eng_i(eng_i), .eng_ready(eng_ready),
    .eng_done_tick(eng_done_tick), .eng_f(eng_f)
  );
  function automatic logic [DW-1:0] fib(input logic [IW-1:0] n);
    logic [DW-1:0] a = 0, b = 1, t;
    for (int k = 0; k < int'(n); k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  assign eng_ready = !eng_busy && !eng_hold;
  assign eng_done_tick = model_done || inj_done;
  assign eng_f = inj_done ? DW'(999) : model_f;
  always @(posedge clk) begin
    if (!reset_n) begin
      eng_busy <= 0;
      eng_cnt <= 0;
      model_done <= 0;
      model_f <= '0;
      eng_idx <= '0;
    end else begin
      model_done <= 0;
      if (eng_start && eng_ready) begin
        eng_busy <= 1;
        eng_cnt <= 3;
        eng_idx <= eng_i;
      end else if (eng_busy) begin
        if (eng_cnt == 1) begin
          model_done <= 1;
          model_f <= fib(eng_idx);
          eng_busy <= 0;
        end else eng_cnt <= eng_cnt - 1;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t d;
    if (eng_start) begin
      chk("start_pulse", 32'(prev_start), 0);
      if (exp_eng.size() == 0) chk("unexpected_eng_start", 1, 0);
      else chk("eng_i", 32'(eng_i), exp_eng.pop_front());
    end
    if (req0_done_tick || req1_done_tick) begin
      chk("single_done", 32'(req0_done_tick && req1_done_tick), 0);
      if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d = exp_done.pop_front();
        chk("done_req", 32'(req1_done_tick), 32'(d.req));
        chk("done_f", 32'(d.req ? req1_f : req0_f), 32'(d.f));
        chk("done_err", 32'(d.req ? req1_err : req0_err), 32'(d.err));
        if (!d.err) chk("done_latency", 32'(prev_eng_done), 1);
      end
    end
    prev_start = eng_start;
    prev_eng_done = eng_done_tick;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input bit n, input int i);
    if (n) begin
      req1_start = 1;
      req1_i = IW'(i);
    end else begin
      req0_start = 1;
      req0_i = IW'(i);
    end
    tick();
    req0_start = 0;
    req1_start = 0;
  endtask
  task automatic expect_txn(input bit r, input int i, input int f, input bit err, input bit issue);
    exp_t d;
    if (issue) exp_eng.push_back(i);
    d.req = r;
    d.f = DW'(f);
    d.err = err;
    exp_done.push_back(d);
  endtask
  task automatic wait_idle();
    int k;
    for (k = 0; k < 60 && !(req0_ready && req1_ready); k++) tick();
    if (k == 60) chk("idle_timeout", 0, 1);
    tick();
  endtask
  task automatic wait_start(input string name);
    int k;
    for (k = 0; k < 20 && !eng_start; k++) tick();
    if (k == 20) chk(name, 0, 1);
  endtask
  task automatic do_reset();
    reset_n = 0;
    tick();
    tick();
    chk("rst_ready0", 32'(req0_ready), 1);
    chk("rst_ready1", 32'(req1_ready), 1);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_done", 32'({req0_done_tick, req1_done_tick, req0_err, req1_err}), 0);
    reset_n = 1;
  endtask
  initial begin
    bit seen_done;
    int k;
    do_reset();
    chk("rst_f0", 32'(req0_f), 0);
    chk("rst_f1", 32'(req1_f), 0);
    expect_txn(0, 10, 55, 0, 1);
    req(0, 10);
    chk("accept_ready0", 32'(req0_ready), 0);
    chk("lat_no_start_yet", 32'(eng_start), 0);
    tick();
    chk("lat_start_2cyc", 32'(eng_start), 1);
    wait_idle();
    chk("ready0_back", 32'(req0_ready), 1);
    do_reset();
    expect_txn(0, 5, 5, 0, 1);
    expect_txn(1, 7, 13, 0, 1);
    req0_start = 1; req0_i = 5; req1_start = 1; req1_i = 7;
    tick();
    req0_start = 0; req1_start = 0;
    wait_idle();
    expect_txn(0, 5, 5, 0, 1);
    expect_txn(1, 7, 13, 0, 1);
    req0_start = 1; req1_start = 1;
    tick();
    req0_start = 0; req1_start = 0;
    wait_idle();
    eng_hold = 1;
    expect_txn(1, 3, 2, 0, 1);
    req(1, 3);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("hold_no_start", 32'(eng_start), 0);
    end
    eng_hold = 0;
    #1;
    chk("hold_release_start", 32'(eng_start), 1);
    tick();
    chk("hold_start_one_cycle", 32'(eng_start), 0);
    wait_idle();
    expect_txn(0, 6, 8, 0, 1);
    expect_txn(1, 4, 3, 0, 1);
    req(0, 6);
    wait_start("t4_start_timeout");
    tick();
    req(1, 4);
    chk("queued_ready1", 32'(req1_ready), 0);
    seen_done = 0;
    for (k = 0; k < 30; k++) begin
      if (req0_done_tick) seen_done = 1;
      if (eng_start) break;
      tick();
    end
    if (k == 30) chk("queued_start_timeout", 0, 1);
    else chk("queued_start_after_done", 32'(seen_done), 1);
    wait_idle();
`ifdef FIB_ARB_RANGE_CHK_EN
    expect_txn(1, 31, 0, 1, 0);
`else
    expect_txn(1, 31, 297693, 0, 1);
`endif
    req(1, 31);
    wait_idle();
    exp_eng.push_back(9);
    req(0, 9);
    wait_start("t6_start_timeout");
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("midrst_ready0", 32'(req0_ready), 1);
    chk("midrst_ready1", 32'(req1_ready), 1);
    chk("midrst_done", 32'({req0_done_tick, req1_done_tick}), 0);
    inj_done = 1;
    tick();
    inj_done = 0;
    tick();
    tick();
    chk("stray_done_f0", 32'(req0_f), 0);
    chk("stray_done_tick", 32'({req0_done_tick, req1_done_tick}), 0);
    chk("stray_ready0", 32'(req0_ready), 1);
    chk("eng_q_empty", 32'(exp_eng.size()), 0);
    chk("done_q_empty", 32'(exp_done.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
